vrf_rd_stream_seq: RTL and testbench
====================================

// Module: vrf_rd_stream_seq
// PURPOSE
//  Read-stream sequencer directly upstream of the 1024x128 dual-port vector RAM wrapper, driving its port B.
//  Accepts one command (base address, word count), issues one port-B read per cycle and returns the words
//  as a valid/ready stream to the lane datapath. Handles the fixed 1-cycle RAM read latency and downstream
//  backpressure with a 2-entry capture buffer.
// PARAMETERS
//  AW     10    RAM address width
//  DEPTH  1024  RAM words; addresses wrap modulo DEPTH
//  DW     128   data word width
//  CW     11    command count width (max count = DEPTH)
// PORTS
//  clk          in   1    clock, all logic on rising edge
//  reset        in   1    synchronous, active-high reset
//  cmd_valid    in   1    command present
//  cmd_ready    out  1    sequencer idle; command accepted when cmd_valid & cmd_ready
//  cmd_base     in   AW   first word address
//  cmd_count    in   CW   number of words to read; 0 = empty command
//  ram_addr_b   out  AW   port-B address to RAM wrapper
//  ram_rden_b   out  1    port-B read strobe; low = RAM holds previous address
//  ram_out_b    in   DW   port-B read data, valid 1 cycle after an issued read
//  out_valid    out  1    stream word available
//  out_ready    in   1    consumer accepts; transfer when out_valid & out_ready
//  out_data     out  DW   stream word
//  out_last     out  1    marks final word of the command
//  busy         out  1    command in progress (not IDLE)
//  done         out  1    1-cycle pulse when a command fully completes
// BEHAVIOUR
//  - Reset: state IDLE; cmd_ready=1 after reset deasserts; ram_rden_b=0, ram_addr_b=0, out_valid=0,
//    out_last=0, out_data=0, busy=0, done=0; buffer and inflight flag cleared.
//  - FSM IDLE -> ISSUE on accept with count>0 (latch addr=base, remaining=count). IDLE -> DONE on accept
//    with count=0. ISSUE -> DRAIN in the cycle the last read issues. DRAIN -> DONE when the last word
//    is popped (out_last & out_ready & out_valid). DONE -> IDLE next cycle; done=1 only in DONE.
//  - Issue rule (ISSUE): issue iff occ + inflight - pop < 2, where occ = buffer entries, inflight = read
//    issued previous cycle, pop = out_valid & out_ready this cycle. On issue: ram_rden_b=1,
//    ram_addr_b=addr, addr<=(addr+1) mod DEPTH, remaining<=remaining-1. No issue: ram_rden_b=0, addr held.
//  - ram_addr_b/ram_rden_b are combinational from registered addr/state/occupancy and out_ready.
//  - Capture: inflight=1 -> ram_out_b pushed into buffer this cycle together with the last flag of its
//    issue. Push and pop in same cycle allowed; buffer never overflows (issue rule guarantees it).
//  - Ordering strictly address order; output is buffer head. Sustained throughput 1 word/cycle while
//    out_ready=1; first word out_valid 2 cycles after command accept.
//  - Wrap: base=1022, count=4 reads 1022,1023,0,1.
//  - out_data/out_last hold stable while out_valid & !out_ready.
//  - cmd_valid ignored outside IDLE. Reset mid-command: aborts immediately, inflight data discarded,
//    no done pulse.
// STRUCTURE
//  - Package vrf_seq_pkg: state enum {IDLE, ISSUE, DRAIN, DONE}; localparam defaults AW/DEPTH/DW/CW.
//  - Sub-module vrf_seq_skid2: 2-entry FIFO of {last, data} with push/pop, occ[1:0], same-cycle push+pop.
//  - Top: FSM, addr/remaining counters, inflight+last-tag register, issue logic.
// TESTING
//  - Reset then cmd base=5,count=3, out_ready=1 -> rden_b at cycles 1..3 addr 5,6,7; words out cycles
//    2..4, out_last on 3rd; done pulse one cycle after last pop; cmd_ready back next cycle.
//  - base=1022,count=4 -> addresses 1022,1023,0,1; data order matches preloaded RAM.
//  - count=8, out_ready held 0 after first word -> at most 2 buffered, ram_rden_b=0 while stalled, no
//    data lost or duplicated; release -> remaining words 1/cycle in order.
//  - Random out_ready toggling, count=1024 -> exactly 1024 words, one out_last, scoreboard match.
//  - count=0 -> no rden_b, no out_valid, done pulse 1 cycle after accept; cmd_valid while busy ignored.
//  - Assert reset during ISSUE with 1 buffered word -> next cycle out_valid=0, rden_b=0, busy=0, no done.

Source files
------------

// File: rtl/vrf_seq_pkg.sv
`default_nettype none
// ============================================================================
// Module      : vrf_seq_pkg
// Description : Shared definitions for the vector-RAM read-stream sequencer.
//               Holds the sequencer state encoding and the default geometry
//               of the 1024x128 dual-port vector RAM it drives.
// Revision    : 1.0 - initial release
// ============================================================================
package vrf_seq_pkg;

    // Default geometry of the vector RAM wrapper (port B side)
    localparam int c_AW    = 10;    // RAM address width
    localparam int c_DEPTH = 1024;  // RAM words, addresses wrap modulo this
    localparam int c_DW    = 128;   // data word width
    localparam int c_CW    = 11;    // command count width (holds DEPTH)

    // Sequencer states
    typedef enum logic [1:0] {
        IDLE  = 2'd0,   // waiting for a command
        ISSUE = 2'd1,   // issuing port-B reads
        DRAIN = 2'd2,   // all reads issued, emptying the capture path
        DONE  = 2'd3    // one-cycle completion state
    } seq_state_e;

endpackage : vrf_seq_pkg
`default_nettype wire

// File: rtl/vrf_seq_skid2.sv
`default_nettype none
// ============================================================================
// Module      : vrf_seq_skid2
// Description : Two-entry FIFO holding {last, data} words captured from the
//               RAM read port. Push and pop may occur in the same cycle.
//               The caller guarantees no push when full and no pop when empty.
// Ports       : clk          in   clock, rising edge
//               reset        in   synchronous active-high reset
//               i_push       in   write i_push_data this cycle
//               i_push_data  in   W-bit entry to store
//               i_pop        in   discard the head entry this cycle
//               o_head       out  head entry (oldest); zero when never written
//               o_occ        out  number of valid entries (0..2)
// Revision    : 1.0 - initial release
// ============================================================================
module vrf_seq_skid2 #(
    parameter int W = 129
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         i_push,
    input  logic [W-1:0] i_push_data,
    input  logic         i_pop,
    output logic [W-1:0] o_head,
    output logic [1:0]   o_occ
);

    logic [W-1:0] r_mem [2];
    logic         r_wr_ptr;
    logic         r_rd_ptr;
    logic [1:0]   r_occ;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_mem[0] <= '0;
            r_mem[1] <= '0;
            r_wr_ptr <= 1'b0;
            r_rd_ptr <= 1'b0;
            r_occ    <= 2'd0;
        end else begin
            if (i_push) begin
                r_mem[r_wr_ptr] <= i_push_data;
                r_wr_ptr        <= ~r_wr_ptr;
            end
            if (i_pop) begin
                r_rd_ptr <= ~r_rd_ptr;
            end
            r_occ <= r_occ + {1'b0, i_push} - {1'b0, i_pop};
        end
    end

    assign o_head = r_mem[r_rd_ptr];
    assign o_occ  = r_occ;

endmodule : vrf_seq_skid2
`default_nettype wire

// File: rtl/vrf_rd_stream_seq.sv
`default_nettype none
// ============================================================================
// Module      : vrf_rd_stream_seq
// Description : Read-stream sequencer driving port B of the vector RAM.
//               Accepts one {base, count} command, issues one read per cycle
//               (addresses wrap modulo DEPTH) and returns the words in
//               address order as a valid/ready stream. The 1-cycle RAM read
//               latency and downstream backpressure are absorbed by a
//               two-entry capture FIFO plus a bypass path for the word
//               arriving from the RAM this cycle.
// Ports       : clk, reset            clock / synchronous active-high reset
//               cmd_valid/cmd_ready   command handshake (ready only in IDLE)
//               cmd_base [AW]         first word address
//               cmd_count [CW]        word count, 0 = empty command
//               ram_addr_b [AW]       port-B address
//               ram_rden_b            port-B read strobe
//               ram_out_b [DW]        port-B read data (1 cycle after read)
//               out_valid/out_ready   stream handshake
//               out_data [DW]         stream word
//               out_last              final word of the command
//               busy                  command in progress (state != IDLE)
//               done                  1-cycle completion pulse
// Revision    : 1.0 - initial release
// ============================================================================
module vrf_rd_stream_seq
    import vrf_seq_pkg::*;
#(
    parameter int AW    = c_AW,
    parameter int DEPTH = c_DEPTH,
    parameter int DW    = c_DW,
    parameter int CW    = c_CW
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          cmd_valid,
    output logic          cmd_ready,
    input  logic [AW-1:0] cmd_base,
    input  logic [CW-1:0] cmd_count,
    output logic [AW-1:0] ram_addr_b,
    output logic          ram_rden_b,
    input  logic [DW-1:0] ram_out_b,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [DW-1:0] out_data,
    output logic          out_last,
    output logic          busy,
    output logic          done
);

    seq_state_e    r_state;
    logic [AW-1:0] r_addr;          // next address to read
    logic [CW-1:0] r_remaining;     // reads still to issue
    logic          r_inflight;      // read issued last cycle, data on ram_out_b now
    logic          r_inflight_last; // that read was the final one of the command

    logic [DW:0]   w_head;          // {last, data} at FIFO head
    logic [1:0]    w_occ;
    logic          w_buf_valid;
    logic          w_pop;
    logic          w_push;
    logic          w_buf_pop;
    logic [2:0]    w_fill;
    logic          w_issue;
    logic [AW-1:0] w_addr_nxt;

    vrf_seq_skid2 #(
        .W (DW + 1)
    ) u_skid (
        .clk         (clk),
        .reset       (reset),
        .i_push      (w_push),
        .i_push_data ({r_inflight_last, ram_out_b}),
        .i_pop       (w_buf_pop),
        .o_head      (w_head),
        .o_occ       (w_occ)
    );

    // Stream output: FIFO head when it holds anything, otherwise the word
    // arriving from the RAM this cycle. An arriving word that is not taken
    // is pushed into the FIFO, so the presented word stays stable under
    // backpressure.
    assign w_buf_valid = (w_occ != 2'd0);
    assign out_valid   = w_buf_valid | r_inflight;

    always_comb begin
        out_data = '0;
        out_last = 1'b0;
        if (w_buf_valid) begin
            out_data = w_head[DW-1:0];
            out_last = w_head[DW];
        end else if (r_inflight) begin
            out_data = ram_out_b;
            out_last = r_inflight_last;
        end
    end

    assign w_pop     = out_valid & out_ready;
    assign w_buf_pop = w_pop & w_buf_valid;
    // The arriving word skips the FIFO only when it is consumed straight away.
    assign w_push    = r_inflight & ~(~w_buf_valid & w_pop);

    // Words held after this cycle = occ + inflight - pop; a new read is safe
    // while that stays below 2, so its data always finds a free entry.
    assign w_fill  = {1'b0, w_occ} + {2'b00, r_inflight};
    assign w_issue = (r_state == ISSUE) && (w_fill < (3'd2 + {2'b00, w_pop}));

    assign ram_rden_b = w_issue;
    assign ram_addr_b = r_addr;

    assign w_addr_nxt = (r_addr == AW'(DEPTH - 1)) ? '0 : r_addr + AW'(1);

    assign cmd_ready = (r_state == IDLE);
    assign busy      = (r_state != IDLE);
    assign done      = (r_state == DONE);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state         <= IDLE;
            r_addr          <= '0;
            r_remaining     <= '0;
            r_inflight      <= 1'b0;
            r_inflight_last <= 1'b0;
        end else begin
            r_inflight      <= w_issue;
            r_inflight_last <= w_issue && (r_remaining == CW'(1));

            if (w_issue) begin
                r_addr      <= w_addr_nxt;
                r_remaining <= r_remaining - CW'(1);
            end

            case (r_state)
                IDLE: begin
                    if (cmd_valid) begin
                        r_addr      <= cmd_base;
                        r_remaining <= cmd_count;
                        r_state     <= (cmd_count == '0) ? DONE : ISSUE;
                    end
                end
                ISSUE: begin
                    if (w_issue && (r_remaining == CW'(1))) begin
                        r_state <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (w_pop && out_last) begin
                        r_state <= DONE;
                    end
                end
                DONE: begin
                    r_state <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

endmodule : vrf_rd_stream_seq
`default_nettype wire

// File: tb/tb_vrf_rd_stream_seq.sv
`default_nettype none
// ============================================================================
// Module      : tb_vrf_rd_stream_seq
// Description : Self-checking bench for vrf_rd_stream_seq. A behavioural
//               1-cycle-latency RAM supplies port-B data; expected addresses
//               and {data,last} words are queued when each command is driven
//               and popped as reads / stream transfers appear.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_vrf_rd_stream_seq;

    logic         clk;
    logic         reset;
    logic         cmd_valid;
    logic         cmd_ready;
    logic [9:0]   cmd_base;
    logic [10:0]  cmd_count;
    logic [9:0]   ram_addr_b;
    logic         ram_rden_b;
    logic [127:0] ram_out_b;
    logic         out_valid;
    logic         out_ready;
    logic [127:0] out_data;
    logic         out_last;
    logic         busy;
    logic         done;

    vrf_rd_stream_seq dut (
        .clk        (clk),
        .reset      (reset),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_base   (cmd_base),
        .cmd_count  (cmd_count),
        .ram_addr_b (ram_addr_b),
        .ram_rden_b (ram_rden_b),
        .ram_out_b  (ram_out_b),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .out_last   (out_last),
        .busy       (busy),
        .done       (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // RAM content pattern, distinct per address
    function automatic logic [127:0] ramword(input int a);
        logic [31:0] x;
        x = 32'(a);
        return {32'hA5A5_0000 ^ x, ~x, x * 32'h9E37_79B1, x ^ 32'h1234_5678};
    endfunction

    logic [127:0] mem [0:1023];
    initial begin
        for (int i = 0; i < 1024; i++) mem[i] = ramword(i);
        ram_out_b = '0;
    end
    always @(posedge clk) if (ram_rden_b) ram_out_b <= mem[ram_addr_b];

    typedef struct packed {
        logic [127:0] d;
        logic         l;
    } exp_t;

    exp_t data_q[$];
    int   addr_q[$];

    int total = 0;
    int bad   = 0;
    bit sb_en = 0;
    int words, lasts, dones, issued;

    logic         s_rden, s_valid, s_last, s_done, s_rdy, s_busy;
    logic [9:0]   s_addr;
    logic [127:0] s_data;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic push_cmd(input int base, input int count);
        for (int i = 0; i < count; i++) begin
            int a;
            a = (base + i) % 1024;
            addr_q.push_back(a);
            data_q.push_back({ramword(a), (i == count - 1)});
        end
    endtask

    task automatic clear_counts();
        words = 0; lasts = 0; dones = 0; issued = 0;
    endtask

    // Sample at the falling edge (what the next rising edge will act on)
    task automatic sample();
        exp_t e;
        int   a;
        s_rden = ram_rden_b; s_addr = ram_addr_b; s_valid = out_valid;
        s_last = out_last;   s_data = out_data;   s_done = done;
        s_rdy  = cmd_ready;  s_busy = busy;
        if (sb_en) begin
            if (ram_rden_b) begin
                issued++;
                if (addr_q.size() == 0) begin
                    total++; bad++;
                    $display("FAIL rd_addr unexpected read actual=%0d required=none", ram_addr_b);
                end else begin
                    a = addr_q.pop_front();
                    chk("rd_addr", 128'(ram_addr_b), 128'(a));
                end
            end
            if (out_valid && out_ready) begin
                words++;
                if (out_last) lasts++;
                if (data_q.size() == 0) begin
                    total++; bad++;
                    $display("FAIL out_word unexpected word actual=%0h required=none", out_data);
                end else begin
                    e = data_q.pop_front();
                    chk("out_data", out_data, e.d);
                    chk("out_last", 128'(out_last), 128'(e.l));
                end
            end
            if (done) dones++;
        end
    endtask

    task automatic cyc();
        @(negedge clk);
        sample();
        @(posedge clk);
        #1;
    endtask

    // Per-cycle expectations for the base=5,count=3 sequence
    typedef struct {
        int rden; int addr; int valid; int last; int dn; int rdy; int bsy;
    } hand_t;
    hand_t hand[6];

    // Command table: mode 0 = always ready, 1 = stall after first word, 2 = random
    typedef struct {
        int base; int count; int mode;
        int exp_words; int exp_lasts; int exp_lat;
    } vec_t;
    vec_t vecs[6];

    initial begin
        logic [127:0] held;
        int           lat, lat_obs, stall_cyc;
        bit           seen;

        hand[0] = '{1, 5, 0, 0, 0, 0, 1};
        hand[1] = '{1, 6, 1, 0, 0, 0, 1};
        hand[2] = '{1, 7, 1, 0, 0, 0, 1};
        hand[3] = '{0, -1, 1, 1, 0, 0, 1};
        hand[4] = '{0, -1, 0, 0, 1, 0, 1};
        hand[5] = '{0, -1, 0, 0, 0, 1, 0};

        vecs[0] = '{1022, 4,    0, 4,    1, 6};
        vecs[1] = '{100,  8,    1, 8,    1, -1};
        vecs[2] = '{0,    1024, 2, 1024, 1, -1};
        vecs[3] = '{7,    0,    0, 0,    0, 1};
        vecs[4] = '{1023, 1,    0, 1,    1, 3};
        vecs[5] = '{513,  37,   2, 37,   1, -1};

        reset = 1'b1; cmd_valid = 1'b0; cmd_base = '0; cmd_count = '0; out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;

        // ---- reset state ----
        cyc();
        chk("rst_cmd_ready", 128'(s_rdy),   128'(1));
        chk("rst_rden",      128'(s_rden),  128'(0));
        chk("rst_addr",      128'(s_addr),  128'(0));
        chk("rst_valid",     128'(s_valid), 128'(0));
        chk("rst_last",      128'(s_last),  128'(0));
        chk("rst_data",      s_data,        128'(0));
        chk("rst_busy",      128'(s_busy),  128'(0));
        chk("rst_done",      128'(s_done),  128'(0));

        // ---- base=5,count=3 cycle-exact, with a command offered while busy ----
        sb_en = 1; clear_counts();
        push_cmd(5, 3);
        cmd_valid = 1'b1; cmd_base = 10'd5; cmd_count = 11'd3; out_ready = 1'b1;
        cyc();
        chk("hand_accept", 128'(s_rdy), 128'(1));
        cmd_valid = 1'b0;
        for (int c = 1; c <= 6; c++) begin
            if (c == 2) begin cmd_valid = 1'b1; cmd_base = 10'd900; cmd_count = 11'd5; end
            if (c == 6) cmd_valid = 1'b0;
            cyc();
            chk("hand_rden",  128'(s_rden),  128'(hand[c-1].rden));
            if (hand[c-1].addr >= 0) chk("hand_addr", 128'(s_addr), 128'(hand[c-1].addr));
            chk("hand_valid", 128'(s_valid), 128'(hand[c-1].valid));
            chk("hand_last",  128'(s_last),  128'(hand[c-1].last));
            chk("hand_done",  128'(s_done),  128'(hand[c-1].dn));
            chk("hand_ready", 128'(s_rdy),   128'(hand[c-1].rdy));
            chk("hand_busy",  128'(s_busy),  128'(hand[c-1].bsy));
        end
        chk("hand_words", 128'(words), 128'(3));
        chk("hand_dones", 128'(dones), 128'(1));
        chk("hand_q_empty", 128'(data_q.size() + addr_q.size()), 128'(0));

        // ---- reset mid-command with one buffered word ----
        sb_en = 0;
        cmd_valid = 1'b1; cmd_base = 10'd300; cmd_count = 11'd8; out_ready = 1'b0;
        cyc();
        cmd_valid = 1'b0;
        cyc();
        cyc();
        reset = 1'b1;
        cyc();
        chk("abort_pre_valid", 128'(s_valid), 128'(1));
        chk("abort_pre_data",  s_data, ramword(300));
        reset = 1'b0;
        cyc();
        chk("abort_valid", 128'(s_valid), 128'(0));
        chk("abort_rden",  128'(s_rden),  128'(0));
        chk("abort_busy",  128'(s_busy),  128'(0));
        chk("abort_ready", 128'(s_rdy),   128'(1));
        seen = 0;
        for (int k = 0; k < 4; k++) begin
            if (s_done) seen = 1;
            cyc();
        end
        if (s_done) seen = 1;
        chk("abort_no_done", 128'(seen), 128'(0));

        // ---- table-driven commands ----
        data_q.delete(); addr_q.delete();
        sb_en = 1;
        for (int v = 0; v < 6; v++) begin
            clear_counts();
            push_cmd(vecs[v].base, vecs[v].count);
            cmd_valid = 1'b1;
            cmd_base  = 10'(vecs[v].base);
            cmd_count = 11'(vecs[v].count);
            out_ready = 1'b1;
            cyc();
            chk("vec_accept", 128'(s_rdy), 128'(1));
            cmd_valid = 1'b0;
            seen = 0; lat = 0; lat_obs = -1; stall_cyc = 0; held = '0;
            while (!seen && lat < 8000) begin
                case (vecs[v].mode)
                    1:       out_ready = (words == 0) || (stall_cyc >= 8);
                    2:       out_ready = 1'($urandom_range(0, 1));
                    default: out_ready = 1'b1;
                endcase
                cyc();
                lat++;
                if (vecs[v].mode == 1 && !out_ready) begin
                    stall_cyc++;
                    if (stall_cyc == 1) held = s_data;
                    if (stall_cyc == 8) begin
                        chk("stall_rden",  128'(s_rden),  128'(0));
                        chk("stall_valid", 128'(s_valid), 128'(1));
                        chk("stall_held",  128'(issued - words), 128'(2));
                        chk("stall_data",  s_data, held);
                    end
                end
                if (s_done) begin seen = 1; lat_obs = lat; end
            end
            chk("vec_done_seen", 128'(seen), 128'(1));
            if (!seen) begin
                $display("FAIL vec_timeout entry=%0d", v);
                $fatal(1, "command did not complete");
            end
            chk("vec_words", 128'(words), 128'(vecs[v].exp_words));
            chk("vec_lasts", 128'(lasts), 128'(vecs[v].exp_lasts));
            chk("vec_dones", 128'(dones), 128'(1));
            chk("vec_q_empty", 128'(data_q.size() + addr_q.size()), 128'(0));
            if (vecs[v].exp_lat >= 0) chk("vec_done_lat", 128'(lat_obs), 128'(vecs[v].exp_lat));
            out_ready = 1'b1;
            cyc();
            chk("vec_idle_ready", 128'(s_rdy),  128'(1));
            chk("vec_idle_done",  128'(s_done), 128'(0));
            chk("vec_idle_busy",  128'(s_busy), 128'(0));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_vrf_rd_stream_seq
`default_nettype wire
